// File: rtl/mem_arb.sv
// mem_arb: two-requester (CPU / byte loader) arbiter onto a single 16-bit
// synchronous memory port. Round-robin on ties, one access in flight at a
// time, three cycles per access (grant, memory cycle, acknowledge).
module mem_arb (
    input  logic        CLK,
    input  logic        AR,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [7:0]  CPU_ADDR,
    input  logic [15:0] CPU_WDATA,
    output logic        CPU_ACK,
    output logic [15:0] CPU_RDATA,
    input  logic        LDR_REQ,
    input  logic [8:0]  LDR_ADDR,
    input  logic [7:0]  LDR_DATA,
    output logic        LDR_ACK,
    output logic [7:0]  LDR_CNT,
    output logic        MSL,
    output logic        MWE,
    output logic        MOE,
    output logic [7:0]  MA,
    output logic [1:0]  MBE,
    output logic [15:0] MDW,
    input  logic [15:0] MDR,
    output logic        BUSY
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_cpu_q, last_cpu_d;   // 1: CPU was served last, 0: loader
    logic            gnt_cpu_q, gnt_cpu_d;     // requester owning the current access
    logic            pick_cpu;

    logic            msl_d, mwe_d, moe_d;
    logic [1:0]      mbe_d;
    logic [AW-1:0]   ma_d;
    logic [DW-1:0]   mdw_d;
    logic            cpu_ack_d, ldr_ack_d, busy_d;
    logic [DW-1:0]   rdata_d;
    logic [CW-1:0]   cnt_d;

    // Next-state, grant selection and next values of all registered outputs
    always_comb begin
        state_d    = state_q;
        last_cpu_d = last_cpu_q;
        gnt_cpu_d  = gnt_cpu_q;
        pick_cpu   = 1'b0;
        msl_d      = 1'b0;
        mwe_d      = 1'b0;
        moe_d      = 1'b0;
        mbe_d      = 2'b00;
        ma_d       = MA;
        mdw_d      = MDW;
        cpu_ack_d  = 1'b0;
        ldr_ack_d  = 1'b0;
        rdata_d    = CPU_RDATA;
        cnt_d      = LDR_CNT;

        case (state_q)
            IDLE: begin
                if (CPU_REQ || LDR_REQ) begin
                    // CPU wins when alone, or on a tie when the loader went last
                    pick_cpu   = CPU_REQ && (!LDR_REQ || !last_cpu_q);
                    gnt_cpu_d  = pick_cpu;
                    last_cpu_d = pick_cpu;
                    msl_d      = 1'b1;
                    state_d    = ACC;
                    if (pick_cpu) begin
                        mwe_d = CPU_WE;
                        moe_d = !CPU_WE;
                        mbe_d = 2'b11;
                        ma_d  = CPU_ADDR;
                        mdw_d = CPU_WDATA;
                    end else begin
                        mwe_d = 1'b1;
                        ma_d  = LDR_ADDR[AW:1];
                        if (LDR_ADDR[0]) begin
                            mbe_d = 2'b10;
                            mdw_d = {LDR_DATA, BW'(0)};
                        end else begin
                            mbe_d = 2'b01;
                            mdw_d = {BW'(0), LDR_DATA};
                        end
                    end
                end
            end
            ACC: begin
                state_d = RESP;
                if (gnt_cpu_q) begin
                    cpu_ack_d = 1'b1;
                    if (MOE) begin
                        rdata_d = MDR;
                    end
                end else begin
                    ldr_ack_d = 1'b1;
                    cnt_d     = CW'(LDR_CNT + CW'(1));
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            state_q    <= IDLE;
            last_cpu_q <= 1'b0;
            gnt_cpu_q  <= 1'b0;
            MSL        <= 1'b0;
            MWE        <= 1'b0;
            MOE        <= 1'b0;
            MBE        <= 2'b00;
            MA         <= '0;
            MDW        <= '0;
            CPU_ACK    <= 1'b0;
            LDR_ACK    <= 1'b0;
            CPU_RDATA  <= '0;
            LDR_CNT    <= '0;
            BUSY       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_cpu_q <= last_cpu_d;
            gnt_cpu_q  <= gnt_cpu_d;
            MSL        <= msl_d;
            MWE        <= mwe_d;
            MOE        <= moe_d;
            MBE        <= mbe_d;
            MA         <= ma_d;
            MDW        <= mdw_d;
            CPU_ACK    <= cpu_ack_d;
            LDR_ACK    <= ldr_ack_d;
            CPU_RDATA  <= rdata_d;
            LDR_CNT    <= cnt_d;
            BUSY       <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and randomized bench for mem_arb with a word-array
// memory device and a transaction-level reference of arbitration and data.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        ar;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        ldr_req;
    logic [8:0]  ldr_addr;
    logic [7:0]  ldr_data;
    logic        ldr_ack;
    logic [7:0]  ldr_cnt;
    logic        msl, mwe, moe;
    logic [7:0]  ma;
    logic [1:0]  mbe;
    logic [15:0] mdw;
    logic [15:0] mdr;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] dev_mem [256];
    logic [15:0] ref_mem [256];

    // reference model: remaining cycles of current access (2 = memory cycle, 1 = ack cycle)
    int          m_left;
    logic        m_cpu, m_last_cpu, m_we;
    logic [7:0]  m_addr;
    logic [1:0]  m_be;
    logic [15:0] m_wd;
    logic [15:0] m_rdata;
    logic [7:0]  m_cnt;

    mem_arb dut (
        .CLK(clk), .AR(ar),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata),
        .LDR_REQ(ldr_req), .LDR_ADDR(ldr_addr), .LDR_DATA(ldr_data),
        .LDR_ACK(ldr_ack), .LDR_CNT(ldr_cnt),
        .MSL(msl), .MWE(mwe), .MOE(moe), .MA(ma), .MBE(mbe), .MDW(mdw), .MDR(mdr),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(int i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 40503 + 12345);
    endfunction

    // memory device: combinational read, lane-masked write on the clock edge
    assign mdr = (msl && moe) ? dev_mem[ma] : 16'h0000;

    initial begin
        for (int i = 0; i < 256; i++) dev_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (msl === 1'b1 && mwe === 1'b1) begin
                if (mbe[0]) dev_mem[ma][7:0]  = mdw[7:0];
                if (mbe[1]) dev_mem[ma][15:8] = mdw[15:8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left     = 0;
        m_last_cpu = 1'b0;
        m_cnt      = 8'd0;
        m_rdata    = 16'd0;
        m_cpu      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_msl"}, msl, 0);
        check({tag, "_mwe"}, mwe, 0);
        check({tag, "_moe"}, moe, 0);
        check({tag, "_mbe"}, mbe, 0);
        check({tag, "_cack"}, cpu_ack, 0);
        check({tag, "_lack"}, ldr_ack, 0);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_cnt"}, ldr_cnt, 0);
    endtask

    // one clock: advance the reference with the inputs held at the edge, then compare
    task automatic step();
        logic acc, resp;
        @(posedge clk);
        if (m_left != 0) begin
            m_left = m_left - 1;
        end else if (cpu_req || ldr_req) begin
            m_cpu      = cpu_req && (!ldr_req || !m_last_cpu);
            m_last_cpu = m_cpu;
            m_left     = 2;
            if (m_cpu) begin
                m_we = cpu_we; m_addr = cpu_addr; m_be = 2'b11; m_wd = cpu_wdata;
            end else begin
                m_we   = 1'b1;
                m_addr = ldr_addr[8:1];
                m_be   = ldr_addr[0] ? 2'b10 : 2'b01;
                m_wd   = ldr_addr[0] ? {ldr_data, 8'h00} : {8'h00, ldr_data};
            end
        end
        if (m_left == 1) begin
            if (m_cpu && !m_we) begin
                m_rdata = ref_mem[m_addr];
            end else begin
                if (m_be[0]) ref_mem[m_addr][7:0]  = m_wd[7:0];
                if (m_be[1]) ref_mem[m_addr][15:8] = m_wd[15:8];
            end
            if (!m_cpu) m_cnt = m_cnt + 8'd1;
        end
        cyc++;
        #1;
        acc  = (m_left == 2);
        resp = (m_left == 1);
        check("busy", busy, m_left != 0);
        check("msl", msl, acc);
        check("mwe", mwe, acc && m_we);
        check("moe", moe, acc && !m_we);
        check("mbe", mbe, acc ? m_be : 2'b00);
        if (acc) check("ma", ma, m_addr);
        if (acc && m_we) check("mdw", mdw, m_wd);
        check("cpu_ack", cpu_ack, resp && m_cpu);
        check("ldr_ack", ldr_ack, resp && !m_cpu);
        check("cpu_rdata", cpu_rdata, m_rdata);
        check("ldr_cnt", ldr_cnt, m_cnt);
    endtask

    // requesters: drop on their ack cycle, otherwise raise new random requests
    task automatic drive_random();
        if (cpu_req && m_left == 1 && m_cpu) begin
            cpu_req = 1'b0;
        end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 8'($urandom_range(0, 15));
            cpu_wdata = 16'($urandom);
            cpu_req   = 1'b1;
        end
        if (ldr_req && m_left == 1 && !m_cpu) begin
            ldr_req = 1'b0;
        end else if (!ldr_req && $urandom_range(0, 2) == 0) begin
            ldr_addr = 9'($urandom_range(0, 31));
            ldr_data = 8'($urandom);
            ldr_req  = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 ar = 1'b0;
        #1 check_reset_outputs("rst");
        model_reset();
        #2 ar = 1'b1;
    endtask

    initial begin
        int   n_ack;
        logic [3:0] order;
        int   bad;

        ar = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        // power-on reset, asynchronous values before any clock edge
        #3 check_reset_outputs("por");
        #9 ar = 1'b1;

        // CPU read of 0x10 on the first edge after release
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        step();
        check("first_edge_msl", msl, 1);
        check("rd_moe", moe, 1);
        check("rd_ma", ma, 8'h10);
        step();
        check("rd_ack", cpu_ack, 1);
        check("rd_data", cpu_rdata, 16'hBEEF);
        cpu_req = 1'b0;
        step();

        // loader byte write 0xA5 to byte address 0x021
        ldr_req = 1'b1; ldr_addr = 9'h021; ldr_data = 8'hA5;
        step();
        check("ldr_ma", ma, 8'h10);
        check("ldr_mbe", mbe, 2'b10);
        check("ldr_mdw", mdw, 16'hA500);
        step();
        check("ldr_ack1", ldr_ack, 1);
        check("ldr_cnt1", ldr_cnt, 8'd1);
        ldr_req = 1'b0;
        step();

        // CPU_REQ dropped during the memory cycle still completes
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h22; cpu_wdata = 16'h1234;
        step();
        cpu_req = 1'b0;
        step();
        check("drop_ack", cpu_ack, 1);
        step();

        // reset during the memory cycle of a CPU write abandons it
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'hDEAD;
        step();
        check("midrst_acc", mwe, 1);
        #2 ar = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        cpu_req = 1'b0;
        #2 ar = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (cpu_ack) n_ack++;
        end
        check("midrst_no_ack", n_ack, 0);

        // both requests held: alternating grants, one ack every three cycles
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        ldr_req = 1'b1; ldr_addr = 9'h00A; ldr_data = 8'h3C;
        n_ack = 0; order = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cpu_ack || ldr_ack) begin
                n_ack++;
                order = {order[2:0], ldr_ack};
            end
        end
        check("alt_count", n_ack, 4);
        check("alt_order", order, 4'b0101);
        cpu_req = 1'b0; ldr_req = 1'b0;
        step();

        // 256 loader writes wrap the counter back to zero
        apply_reset();
        for (int n = 0; n < 256; n++) begin
            ldr_req = 1'b1; ldr_addr = 9'($urandom_range(0, 511)); ldr_data = 8'($urandom);
            step();
            step();
            ldr_req = 1'b0;
            if (n == 254) check("cnt_255", ldr_cnt, 8'd255);
            step();
        end
        check("cnt_wrap", ldr_cnt, 8'd0);

        // randomized traffic from both requesters
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            step();
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        for (int i = 0; i < 4; i++) step();

        bad = 0;
        for (int i = 0; i < 256; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
        check("mem_final", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have ports: AR  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: CPU_REQ  in  1  CPU access request, level.
REQ-004 SHALL have ports: CPU_WE  in  1  CPU write (1) / read (0).
REQ-005 SHALL have ports: CPU_ADDR  in  8  CPU word address.
REQ-006 SHALL have ports: CPU_WDATA  in  16  CPU write data.
REQ-007 SHALL have ports: CPU_ACK  out  1  one-cycle completion pulse to CPU.
REQ-008 SHALL have ports: CPU_RDATA  out  16  CPU read data, registered.
REQ-009 SHALL have ports: LDR_REQ  in  1  loader byte-write request, level.
REQ-010 SHALL have ports: LDR_ADDR  in  9  loader byte address; bit 0 selects byte lane.
REQ-011 SHALL have ports: LDR_DATA  in  8  loader write byte.
REQ-012 SHALL have ports: LDR_ACK  out  1  one-cycle completion pulse to loader.
REQ-013 SHALL have ports: LDR_CNT  out  8  count of completed loader writes.
REQ-014 SHALL have ports: MSL, MWE, MOE  out  1 each  memory select, write enable, output enable.
REQ-015 SHALL have ports: MA  out  8  memory word address.
REQ-016 SHALL have ports: MBE  out  2  memory byte enables; bit 1 = high byte [15:8].
REQ-017 SHALL have ports: MDW  out  16  memory write data.
REQ-018 SHALL have ports: MDR  in  16  memory read data, valid combinationally while MSL=1 and MOE=1.
REQ-019 SHALL have ports: BUSY  out  1  high in any non-IDLE state.

Function
REQ-020 SHALL implement a 3-state FSM: IDLE, ACC, RESP.
REQ-021 SHALL, in IDLE with no request, remain in IDLE.
REQ-022 SHALL, in IDLE with exactly one request, grant that requester and latch its address, data, WE and lanes, then go to ACC.
REQ-023 SHALL, in IDLE with both requests, grant the requester not recorded as last served; LAST resets to LDR, so the CPU wins the first tie.
REQ-024 SHALL update LAST to the granted requester when leaving IDLE.
REQ-025 SHALL, in ACC, drive MSL=1 and MA=latched address for exactly one cycle.
REQ-026 SHALL, in ACC for a CPU write, drive MWE=1, MOE=0, MBE=11 and MDW=latched CPU_WDATA.
REQ-027 SHALL, in ACC for a CPU read, drive MWE=0, MOE=1 and MBE=11, and capture MDR into CPU_RDATA at the end of the cycle.
REQ-028 SHALL, in ACC for a loader write, drive MWE=1, MOE=0 and MA=LDR_ADDR[8:1].
REQ-029 SHALL, in ACC for a loader write, drive MBE=01 and MDW={8'h00,LDR_DATA} when LDR_ADDR[0]=0.
REQ-030 SHALL, in ACC for a loader write, drive MBE=10 and MDW={LDR_DATA,8'h00} when LDR_ADDR[0]=1.
REQ-031 SHALL, in RESP, pulse the granted requester's ACK for one cycle, then return to IDLE.
REQ-032 SHALL hold MSL, MWE and MOE low and MBE=00 outside ACC; MA and MDW are don't-care.
REQ-033 SHALL give a latency of request sampled in IDLE at edge k, ACC in cycle k+1 and ACK in cycle k+2; the minimum repeat period is 3 cycles per requester.
REQ-034 SHALL ignore requests during ACC and RESP; the competing request waits in IDLE.
REQ-035 SHALL treat a REQ still high in the cycle after ACK as a new request; requesters drop REQ on the ACK cycle.
REQ-036 SHALL complete a latched access even if REQ deasserts before ACK.
REQ-037 SHALL hold CPU_RDATA between CPU reads; it is not updated by writes or loader accesses.
REQ-038 SHALL increment LDR_CNT on each LDR_ACK, wrapping from 255 to 0.

Reset
REQ-039 SHALL, while AR=0, force FSM=IDLE, LAST=LDR, LDR_CNT=0, CPU_RDATA=0, all ACKs=0, MSL=MWE=MOE=0, MBE=00 and BUSY=0, independent of CLK.
REQ-040 SHALL abandon any in-flight access when reset asserts mid-operation; no ACK is issued for it after release.
REQ-041 SHALL evaluate requests on the first rising edge after AR rises.

Verification
REQ-042 SHALL be verified: CPU read of addr 0x10 with MDR=0xBEEF -> MSL/MOE high in cycle k+1; CPU_ACK in k+2 with CPU_RDATA=0xBEEF.
REQ-043 SHALL be verified: loader writes 0xA5 to byte addr 0x021 -> MA=0x10, MBE=10, MDW=0xA500; LDR_ACK; LDR_CNT=1.
REQ-044 SHALL be verified: both REQ held high continuously -> grants alternate CPU, LDR, CPU, LDR…, with one ACK every 3 cycles.
REQ-045 SHALL be verified: 256 loader writes -> LDR_CNT returns to 0.
REQ-046 SHALL be verified: AR pulled low during ACC of a CPU write -> outputs at reset values immediately; no CPU_ACK after release.
REQ-047 SHALL be verified: CPU_REQ drops in cycle k+1 -> access still completes and CPU_ACK pulses in cycle k+2.
